inst_cache: RTL
===============

// Module: inst_cache
// PURPOSE
//  Direct-mapped instruction cache between ifetch and memory. Ifetch sends a PC; a hit returns the
//  32-bit fetch word one cycle later. A miss drives cache2mem_upd_en/cache2mem_PC until memory answers
//  (mem2cache_upd), then writes the line and returns the word. Entries are halfword-addressed for RV32C.
// PARAMETERS
//  CACHE_LINES  16  entries; index = pc[4:1] (`INDEX_WIDTH), tag = pc[31:5] (`TAG_WIDTH)
// PORTS
//  clk              in   1   clock, all state on posedge
//  rst_in           in   1   reset, asynchronous, active-low
//  rdy_in           in   1   global enable; 0 = hold all state
//  flush            in   1   mispredict flush, synchronous
//  if2cache_en      in   1   fetch request, held until cache2if_rdy
//  if2cache_pc      in   32  fetch PC, halfword aligned, stable while if2cache_en
//  cache2if_rdy     out  1   one-cycle pulse: cache2if_inst valid
//  cache2if_inst    out  32  fetch word at PC (low half only meaningful if compressed)
//  cache2if_pc      out  32  PC of returned word
//  cache2mem_upd_en out  1   miss request, level
//  cache2mem_PC     out  32  miss PC, stable while cache2mem_upd_en
//  mem2cache_upd    in   1   fill done pulse
//  mem2cache_idx    in   4   fill index
//  mem2cache_tag    in   27  fill tag
//  mem2cache_PC     in   32  fill PC
//  mem_inst         in   32  fill word
//  is_c_inst        in   1   fill word low half is compressed
//  sec_inst_index   in   4   index of pc+2 (SEC_FILL_EN only)
//  sec_inst_tag     in   27  tag of pc+2 (SEC_FILL_EN only)
// BEHAVIOUR
//  Reset (rst_in=0): valid[] all 0, FSM=IDLE, cache2if_rdy=0, cache2if_inst=0, cache2if_pc=0,
//   cache2mem_upd_en=0, cache2mem_PC=0. Data/tag arrays not reset.
//  rdy_in=0: no state or output register changes.
//  FSM IDLE: if2cache_en & !cache2if_rdy -> look up pc[4:1]. Hit (valid & tag eq): next edge
//   cache2if_rdy=1, inst=data[idx], pc=if2cache_pc; stay IDLE. Miss: next edge upd_en=1,
//   cache2mem_PC=if2cache_pc, -> MISS.
//  IDLE never re-issues a lookup in the cycle cache2if_rdy=1 (ifetch updates PC that cycle).
//  MISS: hold upd_en/PC. On mem2cache_upd & mem2cache_PC==cache2mem_PC: write data[idx]=mem_inst,
//   tag, valid=1; same edge upd_en=0, cache2if_rdy=1, inst=mem_inst, pc=mem2cache_PC -> IDLE.
//   Fill with mismatched PC: ignored, stay MISS.
//  Hit latency 1 cycle; miss latency = memory latency + 1 (cache2if_rdy the cycle after mem2cache_upd).
//  cache2if_rdy is a one-cycle pulse; cleared on every following enabled edge.
//  flush: highest priority after reset; upd_en=0, cache2if_rdy=0, FSM->IDLE; valid[] kept;
//   fill arriving on flush edge is not written. Flush during MISS leaves memory to self-abort.
//  Same-index fill overwrites; no replacement policy (direct-mapped).
//  Lookup and fill never collide: lookups only occur in IDLE.
//  upd_en stays high if memory is preempted by LSB; cache waits indefinitely.
// CONFIGURATION
//  INST_CACHE_SEC_FILL_EN defined: on a fill with is_c_inst=1 and mem_inst[17:16]!=2'b11, also write
//   entry sec_inst_index with tag sec_inst_tag, data {16'b0, mem_inst[31:16]}, valid=1. If both
//   indices equal, second write wins. Undefined: only the primary entry is written; sec_* ignored.
// STRUCTURE
//  `ADDR_WIDTH, `INST_WIDTH, `INDEX_WIDTH, `TAG_WIDTH and FSM state encodings (IDLE=1'b0,
//  MISS=1'b1) live in util.v. One sub-module: icache_array (valid/tag/data storage, async read,
//  one write port, second write port under INST_CACHE_SEC_FILL_EN, async active-low clear of valid).
// TESTING
//  1 Reset then if2cache_en, pc=0x0000_0010 -> upd_en=1, cache2mem_PC=0x10 next cycle; no rdy.
//  2 Fill pc=0x10, mem_inst=0x0010_0513 -> rdy pulse next cycle, inst=0x00100513; re-fetch 0x10 hits
//    in 1 cycle, upd_en stays 0.
//  3 Conflict: fill 0x10 then fetch 0x30 (same idx 8) -> miss; after fill, fetch 0x10 misses again.
//  4 Flush during MISS at pc=0x40, then fill for 0x40 arrives -> not written, rdy stays 0; later
//    fetch 0x40 misses.
//  5 SEC_FILL_EN: fill pc=0x20, mem_inst=0x4505_4501 -> fetch 0x22 hits, inst=0x0000_4505;
//    without macro fetch 0x22 misses.
//  6 rdy_in=0 for 3 cycles during MISS with fill pulse masked -> outputs frozen; async reset
//    mid-MISS -> upd_en=0 immediately, all valid cleared.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// ---------------------------------------------------------------------------
// | inst_cache_pkg : widths and FSM encoding shared by the instruction cache |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

package inst_cache_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int INST_WIDTH  = 32;
    localparam int INDEX_WIDTH = 4;
    localparam int TAG_WIDTH   = 27;
    localparam int CACHE_LINES = 1 << INDEX_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// | icache_array : valid/tag/data storage, async read, fill write port(s)    |
// | Optional: INST_CACHE_SEC_FILL_EN adds a second write port                |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module icache_array
    import inst_cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [INST_WIDTH-1:0]  rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [INST_WIDTH-1:0]  wr_data
`ifdef INST_CACHE_SEC_FILL_EN
    ,
    input  logic                   wr2_en,
    input  logic [INDEX_WIDTH-1:0] wr2_idx,
    input  logic [TAG_WIDTH-1:0]   wr2_tag,
    input  logic [INST_WIDTH-1:0]  wr2_data
`endif
);

    logic [CACHE_LINES-1:0] valid;
    logic [TAG_WIDTH-1:0]   tags [CACHE_LINES];
    logic [INST_WIDTH-1:0]  data [CACHE_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (wr_en)
                valid[wr_idx] <= 1'b1;
`ifdef INST_CACHE_SEC_FILL_EN
            if (wr2_en)
                valid[wr2_idx] <= 1'b1;
`endif
        end
    end

    // Tag/data are not reset; the second port is written last so it wins on equal indices.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
`ifdef INST_CACHE_SEC_FILL_EN
        if (wr2_en) begin
            tags[wr2_idx] <= wr2_tag;
            data[wr2_idx] <= wr2_data;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/inst_cache.sv
// ---------------------------------------------------------------------------
// | inst_cache : direct-mapped, halfword-indexed instruction cache           |
// | Optional: INST_CACHE_SEC_FILL_EN also fills the pc+2 compressed entry    |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module inst_cache
    import inst_cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush,
    input  logic                   if2cache_en,
    input  logic [ADDR_WIDTH-1:0]  if2cache_pc,
    output logic                   cache2if_rdy,
    output logic [INST_WIDTH-1:0]  cache2if_inst,
    output logic [ADDR_WIDTH-1:0]  cache2if_pc,
    output logic                   cache2mem_upd_en,
    output logic [ADDR_WIDTH-1:0]  cache2mem_PC,
    input  logic                   mem2cache_upd,
    input  logic [INDEX_WIDTH-1:0] mem2cache_idx,
    input  logic [TAG_WIDTH-1:0]   mem2cache_tag,
    input  logic [ADDR_WIDTH-1:0]  mem2cache_PC,
    input  logic [INST_WIDTH-1:0]  mem_inst,
    input  logic                   is_c_inst,
    input  logic [INDEX_WIDTH-1:0] sec_inst_index,
    input  logic [TAG_WIDTH-1:0]   sec_inst_tag
);

    state_t                 state;
    logic                   rd_valid;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [INST_WIDTH-1:0]  rd_data;
    logic                   hit;
    logic                   fill_match;
    logic                   fill_wr;

    assign hit        = rd_valid && (rd_tag == if2cache_pc[ADDR_WIDTH-1:ADDR_WIDTH-TAG_WIDTH]);
    assign fill_match = (state == MISS) && mem2cache_upd && (mem2cache_PC == cache2mem_PC);
    // A fill coinciding with a flush or a stalled cycle must not reach the array.
    assign fill_wr    = rdy_in && !flush && fill_match;

`ifdef INST_CACHE_SEC_FILL_EN
    logic fill2_wr;
    assign fill2_wr = fill_wr && is_c_inst && (mem_inst[17:16] != 2'b11);
`else
    logic unused_sec;
    assign unused_sec = ^{is_c_inst, sec_inst_index, sec_inst_tag};
`endif

    icache_array u_array (
        .clk      (clk),
        .rst_n    (rst_in),
        .rd_idx   (if2cache_pc[INDEX_WIDTH:1]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_wr),
        .wr_idx   (mem2cache_idx),
        .wr_tag   (mem2cache_tag),
        .wr_data  (mem_inst)
`ifdef INST_CACHE_SEC_FILL_EN
        ,
        .wr2_en   (fill2_wr),
        .wr2_idx  (sec_inst_index),
        .wr2_tag  (sec_inst_tag),
        .wr2_data ({16'b0, mem_inst[31:16]})
`endif
    );

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            cache2if_rdy     <= 1'b0;
            cache2if_inst    <= '0;
            cache2if_pc      <= '0;
            cache2mem_upd_en <= 1'b0;
            cache2mem_PC     <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                state            <= IDLE;
                cache2if_rdy     <= 1'b0;
                cache2mem_upd_en <= 1'b0;
            end else begin
                cache2if_rdy <= 1'b0;
                case (state)
                    IDLE: begin
                        // Skip the cycle rdy is high: ifetch is still moving to its next PC.
                        if (if2cache_en && !cache2if_rdy) begin
                            if (hit) begin
                                cache2if_rdy  <= 1'b1;
                                cache2if_inst <= rd_data;
                                cache2if_pc   <= if2cache_pc;
                            end else begin
                                cache2mem_upd_en <= 1'b1;
                                cache2mem_PC     <= if2cache_pc;
                                state            <= MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (fill_match) begin
                            cache2mem_upd_en <= 1'b0;
                            cache2if_rdy     <= 1'b1;
                            cache2if_inst    <= mem_inst;
                            cache2if_pc      <= mem2cache_PC;
                            state            <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
